// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute-stage ALU.
// Provides op and FSM state encodings plus slice geometry.
package alu_pkg;

  // Chunk width is fixed by adder_16 and must not be overridden.
  localparam int unsigned SLICE_W    = 16;
  localparam int unsigned WIDTH      = 64;
  localparam int unsigned NUM_SLICES = WIDTH / SLICE_W;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_16.sv
// 16-bit Kogge-Stone prefix adder with carry-in.
// Ports:
//   A, B  in  16  addends
//   Cin   in  1   carry-in
//   O     out 17  {carry-out, sum[15:0]}
module adder_16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [16:0] O
);

  function automatic logic [16:0] ks_add(input logic [15:0] x, input logic [15:0] y,
                                         input logic ci);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gn;
    logic [15:0] pn;
    logic [15:0] hs;
    logic [16:0] c;
    g  = x & y;
    p  = x ^ y;
    hs = p;
    // Fold carry-in into bit 0 so the prefix tree yields true carries.
    g[0] = g[0] | (p[0] & ci);
    for (int d = 1; d < 16; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < 16; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    // After the tree, g[i] is the carry out of bit i.
    c = {g, ci};
    return {c[16], hs ^ c[15:0]};
  endfunction

  always_comb begin
    O = ks_add(A, B, Cin);
  end

endmodule

// File: rtl/alu64_seq.sv
// Multi-cycle 64-bit execute-stage ALU. Operands are processed in 16-bit chunks,
// LSB first, through a single shared adder_16 with the carry chained between chunks.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake from decode (in_ready only in IDLE)
//   op, a, b              op code (ADD/SUB/AND/XOR) and operands; SUB is a-b
//   out_valid / out_ready result handshake to memory stage
//   result, cf, zf, sf, of  result and Y86 condition codes, held until next completion
module alu64_seq
  import alu_pkg::*;
#(
  // Must be a multiple of SLICE_W.
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int unsigned NSLC  = WIDTH / SLICE_W;
  localparam int unsigned CNT_W = (NSLC > 1) ? $clog2(NSLC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cf_q, cf_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  logic [SLICE_W-1:0] add_a;
  logic [SLICE_W-1:0] add_b;
  logic [SLICE_W:0]   add_o;
  logic [SLICE_W-1:0] slice_res;
  logic               arith;

  adder_16 u_adder (
    .A   (add_a),
    .B   (add_b),
    .Cin (carry_q),
    .O   (add_o)
  );

  assign add_a = a_q[int'(cnt_q) * SLICE_W +: SLICE_W];
  assign add_b = b_q[int'(cnt_q) * SLICE_W +: SLICE_W];
  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_comb begin
    unique case (op_q)
      OP_AND:  slice_res = add_a & add_b;
      OP_XOR:  slice_res = add_a ^ add_b;
      default: slice_res = add_o[SLICE_W-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    result_d = result_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          op_d  = op_e'(op);
          // SUB is a + ~b + 1: invert b here, seed the chain's carry with 1.
          b_d     = (op == OP_SUB) ? ~b : b;
          carry_d = (op == OP_SUB);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d[int'(cnt_q) * SLICE_W +: SLICE_W] = slice_res;
        carry_d = add_o[SLICE_W];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Result and flags only become visible once the whole word is done.
          state_d  = ST_DONE;
          result_d = acc_d;
          cf_d     = arith & add_o[SLICE_W];
          of_d     = arith & (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                     (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          zf_d     = (acc_d == '0);
          sf_d     = acc_d[WIDTH-1];
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule

// File: tb/tb_alu64_seq.sv
// Directed self-checking bench for alu64_seq: arithmetic/logic vectors with
// hand-computed results and flags, latency, backpressure and mid-run reset.
module tb_alu64_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        cf, zf, sf, of;

  int n_checks;
  int n_errs;

  alu64_seq #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cf        (cf),
    .zf        (zf),
    .sf        (sf),
    .of        (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags packed as {cf, zf, sf, of}.
  function automatic logic [63:0] flags();
    return {60'd0, cf, zf, sf, of};
  endfunction

  // Issue one op, measure latency to out_valid; leaves the DUT in DONE.
  task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
    int n;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    check_eq("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '0; b = '0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency", 64'(n), 64'd4);
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("idle_after_hs", {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] r;
    logic [3:0]  f;  // {cf, zf, sf, of}
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; a = '0; b = '0;

    vecs[0] = '{2'd0, 64'h0000_0000_0000_FFFF, 64'd1, 64'h0000_0000_0001_0000, 4'b0000,
                "add_chain"};
    vecs[1] = '{2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0011,
                "add_ovf"};
    vecs[2] = '{2'd1, 64'd5, 64'd5, 64'd0, 4'b1100, "sub_eq"};
    vecs[3] = '{2'd1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, "sub_borrow"};
    vecs[4] = '{2'd3, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'd0, 4'b0100,
                "xor_self"};
    vecs[5] = '{2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                64'hF000_F000_F000_F000, 4'b0010, "and_mask"};
    vecs[6] = '{2'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1001,
                "sub_ovf"};
    vecs[7] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1100, "add_wrap"};

    #12;
    check_eq("reset_ready_valid", {62'd0, in_ready, out_valid}, 64'b10);
    check_eq("reset_result", result, 64'd0);
    check_eq("reset_flags", flags(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y);
      check_eq({vecs[i].name, "_result"}, result, vecs[i].r);
      check_eq({vecs[i].name, "_flags"}, flags(), {60'd0, vecs[i].f});
      handshake();
      check_eq({vecs[i].name, "_hold"}, result, vecs[i].r);
    end

    // Backpressure: stall in DONE, stray in_valid must be ignored.
    issue(2'd0, 64'h1234, 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 2'd3; a = 64'hAAAA; b = 64'h5555;
      check_eq("bp_result", result, 64'h1235);
      check_eq("bp_flags", flags(), 64'd0);
      check_eq("bp_ready_valid", {62'd0, in_ready, out_valid}, 64'b01);
    end
    @(negedge clk);
    in_valid = 1'b0;
    handshake();
    issue(2'd1, 64'd10, 64'd3);
    check_eq("after_bp_result", result, 64'd7);
    check_eq("after_bp_flags", flags(), 64'b1000);
    handshake();

    // Reset during RUN with counter == 2: accept edge, then two more edges.
    @(negedge clk);
    op = 2'd0; a = 64'hFFFF_FFFF_0000_0001; b = 64'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ready_valid", {62'd0, in_ready, out_valid}, 64'b10);
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_flags", flags(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check_eq("no_stale_valid", {63'd0, out_valid}, 64'd0);
    end
    issue(2'd0, 64'd3, 64'd4);
    check_eq("post_rst_result", result, 64'd7);
    check_eq("post_rst_flags", flags(), 64'd0);
    handshake();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
